// File: rtl/game_controller_if.sv
// Signal bundle between the game controller and its surroundings:
// keyboard/video/physics events in, brick mask, lives, score and mode flags out.
interface game_controller_if;
    logic [7:0]  keycode;
    logic        frame_tick;
    logic        brick_hit;
    logic [4:0]  brick_idx;
    logic        ball_lost;

    logic [31:0] Block_Array;
    logic [1:0]  lives;
    logic [15:0] curr_score;
    logic        start_menu;
    logic        run;
    logic        ball_reset;
    logic        game_over;
    logic        game_won;

    modport master (
        output keycode, frame_tick, brick_hit, brick_idx, ball_lost,
        input  Block_Array, lives, curr_score, start_menu, run,
               ball_reset, game_over, game_won
    );

    modport slave (
        input  keycode, frame_tick, brick_hit, brick_idx, ball_lost,
        output Block_Array, lives, curr_score, start_menu, run,
               ball_reset, game_over, game_won
    );
endinterface

// File: rtl/game_controller.sv
// Breakout-style game sequencer: menu, serve delay, play with brick scoring
// and lives, and game-over / win screens. All outputs are registered and
// reflect the state entered at the edge that consumed the causing input.
//
// state | meaning
// MENU  | title screen; waits for a key release (armed) then a start key
// SERVE | ball parked; counts SERVE_FRAMES frame ticks, then play
// PLAY  | ball and paddle move; bricks score, lost balls cost lives
// OVER  | no lives left; board held for display until Enter
// WIN   | all bricks cleared; board held for display until Enter
module game_controller #(
    parameter int POINTS_PER_BRICK = 10,
    parameter int SERVE_FRAMES     = 60,
    parameter int SCORE_MAX        = 9999
) (
    input logic               clk,
    input logic               Reset,
    game_controller_if.slave  gif
);

    typedef enum logic [2:0] {
        MENU  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        OVER  = 3'd3,
        WIN   = 3'd4
    } state_t;

    localparam int          CW         = $clog2(SERVE_FRAMES + 1);
    localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
    localparam logic [7:0]  KEY_ENTER  = 8'h28;

    state_t        state, state_nxt;
    logic          armed_q;
    logic [CW-1:0] serve_cnt;
    logic [31:0]   blocks_q;
    logic [1:0]    lives_q;
    logic [15:0]   score_q;

    logic          key_blocked;
    logic          hit_valid;
    logic [31:0]   blocks_after;
    logic          hit_last;
    logic [16:0]   score_sum;
    logic [15:0]   score_sat;
    logic          serve_entry;
    logic          restart;

    logic start_menu_d, run_d, ball_reset_d, game_over_d, game_won_d;
    logic start_menu_q, run_q, ball_reset_q, game_over_q, game_won_q;

    // Keys that never start a game (none, 'a', 'd', space), plus brick/score arithmetic.
    always_comb begin
        key_blocked  = (gif.keycode == 8'h00) || (gif.keycode == 8'h04) ||
                       (gif.keycode == 8'h07) || (gif.keycode == 8'h2C);
        hit_valid    = (state == PLAY) && gif.brick_hit && blocks_q[gif.brick_idx];
        blocks_after = hit_valid ? (blocks_q & ~(32'd1 << gif.brick_idx)) : blocks_q;
        hit_last     = hit_valid && (blocks_after == 32'd0);
        score_sum    = {1'b0, score_q} + 17'(POINTS_PER_BRICK);
        score_sat    = (score_sum > 17'(SCORE_MAX)) ? 16'(SCORE_MAX) : score_sum[15:0];
    end

    // State register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state <= MENU;
        else        state <= state_nxt;
    end

    // Next-state decode; a winning hit takes priority over a simultaneous ball loss.
    always_comb begin
        state_nxt = state;
        case (state)
            MENU:  if (armed_q && !key_blocked) state_nxt = SERVE;
            SERVE: if (gif.frame_tick && (serve_cnt == SERVE_LAST)) state_nxt = PLAY;
            PLAY: begin
                if (hit_last)           state_nxt = WIN;
                else if (gif.ball_lost) state_nxt = (lives_q <= 2'd1) ? OVER : SERVE;
            end
            OVER, WIN: if (gif.keycode == KEY_ENTER) state_nxt = MENU;
            default:   state_nxt = MENU;
        endcase
    end

    // Output decode from the state being entered, so flags line up with the new state.
    always_comb begin
        serve_entry  = (state_nxt == SERVE) && (state != SERVE);
        restart      = ((state == OVER) || (state == WIN)) && (state_nxt == MENU);
        start_menu_d = (state_nxt == MENU);
        run_d        = (state_nxt == PLAY);
        ball_reset_d = serve_entry;
        game_over_d  = (state_nxt == OVER);
        game_won_d   = (state_nxt == WIN);
    end

    // Registered mode flags.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            start_menu_q <= 1'b1;
            run_q        <= 1'b0;
            ball_reset_q <= 1'b0;
            game_over_q  <= 1'b0;
            game_won_q   <= 1'b0;
        end else begin
            start_menu_q <= start_menu_d;
            run_q        <= run_d;
            ball_reset_q <= ball_reset_d;
            game_over_q  <= game_over_d;
            game_won_q   <= game_won_d;
        end
    end

    // Game datapath: arm flag, serve counter, brick mask, lives and score.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            armed_q   <= 1'b0;
            serve_cnt <= '0;
            blocks_q  <= 32'hFFFF_FFFF;
            lives_q   <= 2'd3;
            score_q   <= 16'd0;
        end else begin
            armed_q <= ((state == MENU) && (state_nxt == MENU)) ?
                       (armed_q | (gif.keycode == 8'h00)) : 1'b0;

            if (serve_entry)
                serve_cnt <= '0;
            else if ((state == SERVE) && gif.frame_tick)
                serve_cnt <= serve_cnt + 1'b1;

            if (restart) begin
                blocks_q <= 32'hFFFF_FFFF;
                lives_q  <= 2'd3;
                score_q  <= 16'd0;
            end else if (state == PLAY) begin
                blocks_q <= blocks_after;
                if (hit_valid)
                    score_q <= score_sat;
                if (gif.ball_lost && !hit_last && (lives_q != 2'd0))
                    lives_q <= lives_q - 2'd1;
            end
        end
    end

    assign gif.Block_Array = blocks_q;
    assign gif.lives       = lives_q;
    assign gif.curr_score  = score_q;
    assign gif.start_menu  = start_menu_q;
    assign gif.run         = run_q;
    assign gif.ball_reset  = ball_reset_q;
    assign gif.game_over   = game_over_q;
    assign gif.game_won    = game_won_q;

endmodule
